// File: rtl/cpu_dbg_pkg.sv
// Shared types for the core run/halt/step controller.
// Command opcodes, halt causes and the sequencer state.
package cpu_dbg_pkg;

  localparam logic [1:0] OP_HALT   = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_STEP   = 2'd2;
  localparam logic [1:0] OP_SET_BP = 2'd3;

  localparam logic [2:0] CAUSE_RESET     = 3'd0;
  localparam logic [2:0] CAUSE_CMD       = 3'd1;
  localparam logic [2:0] CAUSE_STEP_DONE = 3'd2;
  localparam logic [2:0] CAUSE_BREAK     = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT   = 3'd4;

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_RUN,
    ST_STEP,
    ST_RDREG
  } state_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Debug host bus: command channel plus register read channel.
// master = host side, slave = run controller.
interface cpu_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        dbg_rd_valid;
  logic        dbg_rd_ready;
  logic [4:0]  dbg_rd_idx;
  logic        dbg_rd_rvalid;
  logic [31:0] dbg_rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    output dbg_rd_valid, dbg_rd_idx,
    input  cmd_ready, dbg_rd_ready,
    input  dbg_rd_rvalid, dbg_rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    input  dbg_rd_valid, dbg_rd_idx,
    output cmd_ready, dbg_rd_ready,
    output dbg_rd_rvalid, dbg_rd_data
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer for the core: gates cpu_en from
// debug commands, a PC breakpoint and a cycle budget.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int MAX_CYCLES = 100,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  cpu_run_ctrl_if.slave    bus,
  input  logic [31:0]      pc_in,
  output logic             cpu_en,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [4:0]       rf_dbg_sel,
  input  logic [31:0]      rf_dbg_data
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  state_t      state;
  logic [31:0] bp_addr;
  logic        bp_en;
  logic        skip_bp;
  logic [31:0] step_left;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic is_run, is_step, is_halted;
  logic timeout, bp_hit;
  logic cmd_fire, rd_fire, halt_cmd;

  assign is_run    = state == ST_RUN;
  assign is_step   = state == ST_STEP;
  assign is_halted = state == ST_HALTED;

  assign timeout = cycle_cnt == MAX_CNT;
  assign bp_hit  = is_run & bp_en & ~skip_bp
                 & (pc_in == bp_addr);
  assign cpu_en  = (is_run & ~bp_hit & ~timeout)
                 | (is_step & ~timeout);
  assign halted  = is_halted | (state == ST_RDREG);

  // A pending command always beats a register read.
  assign bus.cmd_ready    = state != ST_RDREG;
  assign bus.dbg_rd_ready = is_halted & ~bus.cmd_valid;
  assign bus.dbg_rd_rvalid = rvalid_q;
  assign bus.dbg_rd_data   = rdata_q;

  assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
  assign rd_fire  = bus.dbg_rd_valid & bus.dbg_rd_ready;
  assign halt_cmd = cmd_fire & (bus.cmd_op == OP_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HALTED;
      cycle_cnt  <= '0;
      bp_addr    <= '0;
      bp_en      <= 1'b0;
      skip_bp    <= 1'b0;
      step_left  <= '0;
      halt_cause <= CAUSE_RESET;
      rf_dbg_sel <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (cpu_en) cycle_cnt <= cycle_cnt + 1'b1;
      if (cmd_fire && bus.cmd_op == OP_SET_BP) begin
        bp_addr <= {bus.cmd_arg[31:2], 2'b00};
        bp_en   <= bus.cmd_arg[0];
      end
      case (state)
        ST_HALTED: begin
          if (cmd_fire) begin
            if (bus.cmd_op == OP_RUN && !timeout) begin
              state   <= ST_RUN;
              skip_bp <= 1'b1;
            end else if (bus.cmd_op == OP_STEP && !timeout
                         && bus.cmd_arg != '0) begin
              state     <= ST_STEP;
              step_left <= bus.cmd_arg;
            end
          end else if (rd_fire) begin
            rf_dbg_sel <= bus.dbg_rd_idx;
            state      <= ST_RDREG;
          end
        end
        ST_RUN: begin
          skip_bp <= 1'b0;
          if (timeout) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_TIMEOUT;
          end else if (bp_hit) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_BREAK;
          end else if (halt_cmd) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_CMD;
          end
        end
        ST_STEP: begin
          step_left <= step_left - 1'b1;
          if (timeout) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_TIMEOUT;
          end else if (step_left == 32'd1) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_STEP_DONE;
          end else if (halt_cmd) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_CMD;
          end
        end
        ST_RDREG: begin
          rdata_q  <= (rf_dbg_sel == 5'd0) ? 32'd0 : rf_dbg_data;
          rvalid_q <= 1'b1;
          state    <= ST_HALTED;
        end
        default: state <= ST_HALTED;
      endcase
    end
  end

endmodule
